// File: rtl/booth_mul_pipe_hs.sv
// Radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned per op.
// Four-stage valid/ready pipeline: encode, 4-2 level, 4-2 tree, final add.
module booth_mul_pipe_hs #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PW = 2*WIDTH + 2;
    localparam int G  = WIDTH/2 + 1;

    function automatic int pow2Ceil(input int n);
        int p;
        p = 4;
        while (p < n) p = p * 2;
        return p;
    endfunction

    // Row count is padded to a power of two so every 4-2 level halves it.
    localparam int R = pow2Ceil(G);
    localparam int H = R / 2;
    localparam int L = $clog2(H) - 1;

    function automatic logic [2*PW-1:0] csa42(input logic [PW-1:0] a, b, c, d);
        logic [PW-1:0] s1, c1, s2, c2;
        s1 = a ^ b ^ c;
        c1 = ((a & b) | (a & c) | (b & c)) << 1;
        s2 = s1 ^ c1 ^ d;
        c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
        return {c2, s2};
    endfunction

    logic             adv;
    logic             s1Valid_q, s2Valid_q, s3Valid_q, outValid_q;
    logic [TAG_W-1:0] s1Tag_q, s2Tag_q, s3Tag_q, outTag_q;
    logic [PW-1:0]    pp_d   [R];
    logic [PW-1:0]    pp_q   [R];
    logic [PW-1:0]    rows_d [H];
    logic [PW-1:0]    rows_q [H];
    logic [PW-1:0]    s3Sum_d, s3Carry_d, s3Sum_q, s3Carry_q;
    logic [2*WIDTH-1:0] outP_d, outP_q;

    assign adv       = out_ready | ~outValid_q;
    assign in_ready  = adv;
    assign out_valid = outValid_q;
    assign out_p     = outP_q;
    assign out_tag   = outTag_q;

    // Unsigned mode zero-extends, so the extra top group recodes b[WIDTH-1].
    always_comb begin
        logic [WIDTH+1:0] aExt;
        logic [WIDTH+2:0] bExt;
        logic [PW-1:0]    aPos, a2Pos, mult;
        aExt  = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
        bExt  = {{2{in_signed & in_b[WIDTH-1]}}, in_b, 1'b0};
        aPos  = {{WIDTH{aExt[WIDTH+1]}}, aExt};
        a2Pos = aPos << 1;
        for (int i = 0; i < R; i++) pp_d[i] = '0;
        for (int i = 0; i < G; i++) begin
            case (bExt[2*i +: 3])
                3'b001, 3'b010: mult = aPos;
                3'b011:         mult = a2Pos;
                3'b100:         mult = -a2Pos;
                3'b101, 3'b110: mult = -aPos;
                default:        mult = '0;
            endcase
            pp_d[i] = mult << (2*i);
        end
    end

    always_comb begin
        for (int g = 0; g < H/2; g++) begin
            {rows_d[2*g+1], rows_d[2*g]} = csa42(pp_q[4*g], pp_q[4*g+1], pp_q[4*g+2], pp_q[4*g+3]);
        end
    end

    always_comb begin
        logic [PW-1:0] cur [H];
        int n;
        for (int i = 0; i < H; i++) cur[i] = rows_q[i];
        for (int lvl = 0; lvl < L; lvl++) begin
            n = H >> lvl;
            for (int g = 0; g < H/4; g++) begin
                if (g < n/4) begin
                    {cur[2*g+1], cur[2*g]} = csa42(cur[4*g], cur[4*g+1], cur[4*g+2], cur[4*g+3]);
                end
            end
        end
        s3Sum_d   = cur[0];
        s3Carry_d = cur[1];
    end

    always_comb begin
        logic [PW-1:0] sum;
        sum    = s3Sum_q + s3Carry_q;
        outP_d = sum[2*WIDTH-1:0];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s3Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else if (flush) begin
            s1Valid_q  <= 1'b0;
            s2Valid_q  <= 1'b0;
            s3Valid_q  <= 1'b0;
            outValid_q <= 1'b0;
        end else if (adv) begin
            s1Valid_q  <= in_valid;
            s2Valid_q  <= s1Valid_q;
            s3Valid_q  <= s2Valid_q;
            outValid_q <= s3Valid_q;
        end
    end

    // Data registers follow adv only; stale contents behind a cleared valid are harmless.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < R; i++) pp_q[i] <= '0;
            for (int i = 0; i < H; i++) rows_q[i] <= '0;
            s1Tag_q   <= '0;
            s2Tag_q   <= '0;
            s3Tag_q   <= '0;
            outTag_q  <= '0;
            s3Sum_q   <= '0;
            s3Carry_q <= '0;
            outP_q    <= '0;
        end else if (adv) begin
            for (int i = 0; i < R; i++) pp_q[i] <= pp_d[i];
            for (int i = 0; i < H; i++) rows_q[i] <= rows_d[i];
            s1Tag_q   <= in_tag;
            s2Tag_q   <= s1Tag_q;
            s3Tag_q   <= s2Tag_q;
            outTag_q  <= s3Tag_q;
            s3Sum_q   <= s3Sum_d;
            s3Carry_q <= s3Carry_d;
            outP_q    <= outP_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_pipe_hs.sv
// Scoreboard bench for booth_mul_pipe_hs: directed vectors, backpressure,
// flush, mid-flight reset and a short mixed-mode random run.
module tb_booth_mul_pipe_hs;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        int          acc;
        bit          chkLat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [3:0]  tag;
        logic [63:0] p;
    } vec_t;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b1;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a = '0;
    logic [WIDTH-1:0]     in_b = '0;
    logic                 in_signed = 1'b0;
    logic [TAG_W-1:0]     in_tag = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb [$];
    vec_t vecs [$];

    bit               holdPrev = 1'b0;
    logic [63:0]      heldP;
    logic [TAG_W-1:0] heldTag;

    booth_mul_pipe_hs #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_tag   (out_tag)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout exp finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] refMul(input logic [31:0] a, b, input logic s);
        logic [63:0] ax, bx;
        ax = s ? {{32{a[31]}}, a} : {32'b0, a};
        bx = s ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Drives one op; the expected result is queued at the cycle it is accepted.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 input logic [3:0] tag, input logic [63:0] p,
                                 input bit keep, input bit chkLat);
        int   waitCnt;
        bit   done;
        exp_t e;
        waitCnt   = 0;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        in_tag    = tag;
        while (!done) begin
            @(negedge sys_clk);
            if (in_ready) begin
                if (keep) begin
                    e.p      = p;
                    e.tag    = tag;
                    e.acc    = cyc;
                    e.chkLat = chkLat;
                    sb.push_back(e);
                end
                done = 1'b1;
            end else if (waitCnt > 50) begin
                checks++;
                errors++;
                $display("[TB] FAIL accept_timeout got in_ready=0 exp in_ready=1");
                done = 1'b1;
            end
            waitCnt++;
            @(posedge sys_clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge sys_clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout got %0d pending exp 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        if (sys_rst) begin
            holdPrev = 1'b0;
        end else begin
            if (holdPrev) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_p", out_p, heldP);
                checkOutput("hold_tag", 64'(out_tag), 64'(heldTag));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out got tag %h p %h exp no result", out_tag, out_p);
                end else begin
                    e = sb.pop_front();
                    checkOutput("product", out_p, e.p);
                    checkOutput("tag", 64'(out_tag), 64'(e.tag));
                    if (e.chkLat) checkOutput("latency", 64'(cyc - e.acc), 64'd4);
                end
            end
            holdPrev = out_valid && !out_ready;
            heldP    = out_p;
            heldTag  = out_tag;
        end
    end

    initial begin
        int expBp [8];
        logic [31:0] ra, rb;
        logic        rs;
        logic [3:0]  rt;
        expBp = '{3, 8, 15, 24, 35, 48, 63, 80};

        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd3, 64'h0000000000000001});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd4, 64'hFFFFFFFE00000001});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 4'd5, 64'h4000000000000000});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 4'd6, 64'h4000000000000000});
        vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b1, 4'd7, 64'hC000000080000000});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000005, 1'b1, 4'd8, 64'hFFFFFFFFFFFFFFFB});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000005, 1'b0, 4'd9, 64'h00000004FFFFFFFB});
        vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 4'd10, 64'h3FFFFFFF00000001});
        vecs.push_back('{32'hFFFFFFFE, 32'h80000000, 1'b1, 4'd11, 64'h0000000100000000});
        vecs.push_back('{32'h00000003, 32'hFFFFFFFD, 1'b1, 4'd12, 64'hFFFFFFFFFFFFFFF7});
        vecs.push_back('{32'h0000FFFF, 32'h0000FFFF, 1'b0, 4'd13, 64'h00000000FFFE0001});
        vecs.push_back('{32'hAAAAAAAA, 32'h00000002, 1'b0, 4'd14, 64'h0000000155555554});
        vecs.push_back('{32'hAAAAAAAA, 32'h00000002, 1'b1, 4'd15, 64'hFFFFFFFF55555554});
        vecs.push_back('{32'h12345678, 32'h00000010, 1'b0, 4'd1, 64'h0000000123456780});
        vecs.push_back('{32'h00000000, 32'hDEADBEEF, 1'b1, 4'd2, 64'h0000000000000000});

        repeat (3) @(posedge sys_clk);
        #1;
        checkOutput("reset_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_p", out_p, 64'd0);
        checkOutput("reset_tag", 64'(out_tag), 64'd0);
        sys_rst = 1'b0;
        #1;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge sys_clk);
        #1;

        $display("[TB] directed vectors, back-to-back mixed mode");
        foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, vecs[i].p, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] mixed-mode random ops against reference");
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            rt = 4'($urandom_range(0, 15));
            if (i % 7 == 0) ra = 32'h80000000;
            if (i % 11 == 0) rb = 32'hFFFFFFFF;
            applyStimulus(ra, rb, rs, rt, refMul(ra, rb, rs), 1'b1, 1'b1);
        end
        waitDrain();

        $display("[TB] backpressure stream");
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    applyStimulus(32'(i + 1), 32'(i + 3), 1'b0, 4'(i), 64'(expBp[i]), 1'b1, 1'b0);
                end
            end
            begin
                repeat (6) @(posedge sys_clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge sys_clk);
                    checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
                    @(posedge sys_clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] flush with ops in flight");
        applyStimulus(32'h11111111, 32'h00000003, 1'b0, 4'd1, 64'h0, 1'b0, 1'b0);
        applyStimulus(32'h22222222, 32'h00000003, 1'b0, 4'd2, 64'h0, 1'b0, 1'b0);
        flush = 1'b1;
        applyStimulus(32'h33333333, 32'h00000003, 1'b0, 4'd3, 64'h0, 1'b0, 1'b0);
        flush = 1'b0;
        applyStimulus(32'h00001000, 32'h00000100, 1'b1, 4'd9, 64'h0000000000100000, 1'b1, 1'b1);
        waitDrain();

        $display("[TB] reset with ops in flight");
        out_ready = 1'b0;
        applyStimulus(32'h00001234, 32'h00000010, 1'b0, 4'd5, 64'h0, 1'b0, 1'b0);
        applyStimulus(32'h00000002, 32'h00000003, 1'b1, 4'd6, 64'h0, 1'b0, 1'b0);
        applyStimulus(32'hFFFFFFFF, 32'h00000002, 1'b1, 4'd7, 64'h0, 1'b0, 1'b0);
        repeat (2) @(posedge sys_clk);
        #1;
        checkOutput("pre_reset_valid", 64'(out_valid), 64'd1);
        checkOutput("pre_reset_p", out_p, 64'h0000000000012340);
        #2;
        sys_rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_p", out_p, 64'd0);
        checkOutput("midrst_tag", 64'(out_tag), 64'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        checkOutput("post_reset_valid", 64'(out_valid), 64'd0);

        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd3, 64'h0000000000000001, 1'b1, 1'b1);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
